// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, byte width and counter sizing for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} arb_state_t;
  localparam int UART_DATA_W = 8;
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first active request at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N < 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  // scan backwards so the lowest offset from ptr is assigned last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) idx = W'((int'(ptr) + i) % N);
    gnt[idx] = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = UART_DATA_W,
  parameter int START_TIMEOUT = 65535,
  localparam int IW = cnt_width(N_REQ),
  localparam int CW = cnt_width(START_TIMEOUT)
) (
  input  logic                    clk_100MHz,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic                    Tx_en,
  output logic [DATA_W-1:0]       Din,
  input  logic                    Tx_done,
  output logic                    err
);
  arb_state_t state;
  logic [1:0] sync;
  logic tx_rdy;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] win_idx;
  logic [N_REQ-1:0] win;
  logic [CW-1:0] cnt;
  assign tx_rdy = sync[1];
  assign busy = state != IDLE;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req(req),
    .ptr(ptr),
    .gnt(win),
    .idx(win_idx)
  );
  // Tx_done is produced in the baud domain, so double-flop it before use
  always_ff @(posedge clk_100MHz)
    sync <= rst ? 2'b00 : {sync[0], Tx_done};
  // grant, launch the transmitter, wait for its start and then its stop bit
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      done <= '0;
      Tx_en <= 1'b0;
      Din <= '0;
      err <= 1'b0;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
    end else begin
      gnt <= '0;
      done <= '0;
      case (state)
        IDLE: if (tx_rdy && |req) begin
          gnt <= win;
          Din <= req_data[int'(win_idx)*DATA_W +: DATA_W];
          Tx_en <= 1'b1;
          owner <= win_idx;
          ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
          cnt <= '0;
          state <= LAUNCH;
        end
        LAUNCH: begin
          cnt <= cnt + CW'(1);
          if (!tx_rdy) begin
            Tx_en <= 1'b0;
            cnt <= '0;
            state <= WAIT_DONE;
          end else if (cnt == CW'(START_TIMEOUT - 1)) begin
            Tx_en <= 1'b0;
            err <= 1'b1;
            cnt <= '0;
            state <= IDLE;
          end
        end
        WAIT_DONE: if (tx_rdy) begin
          done[owner] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
